// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
// Pipeline advance sequencer for the 5-stage core. It handles load-use
// stalls, taken-branch flushes, the HALT drain and single-step advance.
// All enables, bubbles and flushes are combinational from the state and the
// inputs. The state, the drain counter and the stall counter update on clk.
// Optional feature macro: STALL_COUNTER_EN. When it is defined, a saturating
// load-use stall counter is built. When it is undefined, stall_count is
// tied to 0.
module hazard_stall_controller #(
  parameter int REG_ADD_WIDTH = 5,
  parameter int DRAIN_CYCLES  = 3,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_read_from_ex,
  input  logic [REG_ADD_WIDTH-1:0] reg_rt_add_from_ex,
  input  logic [REG_ADD_WIDTH-1:0] reg_rs_add_from_dec,
  input  logic [REG_ADD_WIDTH-1:0] reg_rt_add_from_dec,
  input  logic                     dec_uses_rt,
  input  logic                     halt_from_dec,
  input  logic                     branch_taken_from_ex,
  input  logic                     run_mode,
  input  logic                     step_req,
  output logic                     pc_write_en,
  output logic                     if_id_write_en,
  output logic                     pipe_en,
  output logic                     id_ex_bubble,
  output logic                     if_id_flush,
  output logic                     halted,
  output logic [CNT_WIDTH-1:0]     stall_count
);

  localparam int DCW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [DCW-1:0] drain_q, drain_d;
  logic           adv;
  logic           load_use;

  assign adv = run_mode | step_req;

  // The register 0 target never creates a dependency. rt only counts when
  // the decode instruction actually reads it.
  assign load_use = mem_read_from_ex
                  & (reg_rt_add_from_ex != '0)
                  & ((reg_rt_add_from_ex == reg_rs_add_from_dec)
                     | (dec_uses_rt & (reg_rt_add_from_ex == reg_rt_add_from_dec)));

  // Pipeline control outputs: reset override first, then per-state priority
  always_comb begin
    pc_write_en    = 1'b0;
    if_id_write_en = 1'b0;
    pipe_en        = 1'b0;
    id_ex_bubble   = 1'b0;
    if_id_flush    = 1'b0;
    halted         = 1'b0;
    if (!rst_n) begin
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
    end else begin
      halted = (state_q == ST_HALTED);
      if (adv) begin
        case (state_q)
          ST_RUN: begin
            if (branch_taken_from_ex) begin
              // The decode instruction is on the wrong path, so its hazards
              // and any HALT it carries are irrelevant.
              pc_write_en    = 1'b1;
              if_id_write_en = 1'b1;
              pipe_en        = 1'b1;
              if_id_flush    = 1'b1;
              id_ex_bubble   = 1'b1;
            end else if (halt_from_dec || load_use) begin
              pipe_en      = 1'b1;
              id_ex_bubble = 1'b1;
            end else begin
              pc_write_en    = 1'b1;
              if_id_write_en = 1'b1;
              pipe_en        = 1'b1;
            end
          end
          ST_DRAIN: begin
            pipe_en      = 1'b1;
            id_ex_bubble = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Next state and drain counter. Nothing moves on a non-advancing cycle.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    if (adv) begin
      case (state_q)
        ST_RUN: begin
          if (!branch_taken_from_ex && halt_from_dec) begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          // A counter of 1 means this cycle is the final drain cycle. Using
          // <= also stops DRAIN_CYCLES=0 from locking up in DRAIN.
          if (drain_q <= DCW'(1)) begin
            state_d = ST_HALTED;
            drain_d = '0;
          end else begin
            drain_d = drain_q - DCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

`ifdef STALL_COUNTER_EN
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic                 stall_inc;

  assign stall_inc = adv & (state_q == ST_RUN) & load_use & ~branch_taken_from_ex;

  // Saturating increment so long runs never wrap back to a small count
  always_comb begin
    stall_d = stall_q;
    if (stall_inc && (stall_q != '1)) begin
      stall_d = stall_q + CNT_WIDTH'(1);
    end
  end

  // Stall counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule
